// File: rtl/cpu_bus_pkg.sv
// Shared types and address map for the SM83 external M-cycle bus responders.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        T2,
        T3,
        T4
    } tstate_t;

    localparam logic [15:0] HRAM_BASE     = 16'hFF80;
    localparam logic [15:0] HRAM_LAST     = 16'hFFFE;
    localparam logic [15:0] IE_ADR        = 16'hFFFF;
    localparam logic [7:0]  BUS_IDLE_DATA = 8'hFF;

endpackage

// File: rtl/hram_mem.sv
// 128x8 synchronous single-port RAM backing high RAM; entry 127 is never addressed.
module hram_mem (
    input  logic       clk,
    input  logic [6:0] addr,
    input  logic       we,
    input  logic       re,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] mem [128];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cpu_hram_responder.sv
// High-RAM (FF80-FFFE) responder on the CPU M-cycle bus.
// Define HRAM_IE_EN to also decode FFFF as the 5-bit IE register.
module cpu_hram_responder
    import cpu_bus_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        mcyc_start,
    input  logic [15:0] adr,
    input  logic        rd,
    input  logic        wr,
    input  logic [7:0]  dout,
    output logic [7:0]  din,
    output logic        din_oe,
    output logic        sel
);

    tstate_t    state;
    logic [6:0] req_idx;
    logic       req_rd;
    logic       req_wr;
    logic       req_ie;

    logic       hram_hit;
    logic       ie_hit;
    logic       req_valid;
    logic       commit;
    logic [7:0] mem_rdata;
    logic [7:0] rd_data;

    assign hram_hit = (adr >= HRAM_BASE) && (adr <= HRAM_LAST);
`ifdef HRAM_IE_EN
    assign ie_hit = (adr == IE_ADR);
`else
    assign ie_hit = 1'b0;
`endif
    assign req_valid = (hram_hit || ie_hit) && (rd || wr);

    // Any mcyc_start restarts the sequence; one in T2/T3 aborts before T4 so nothing commits.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            req_idx <= '0;
            req_rd  <= 1'b0;
            req_wr  <= 1'b0;
            req_ie  <= 1'b0;
            sel     <= 1'b0;
            din_oe  <= 1'b0;
        end else if (mcyc_start) begin
            din_oe <= 1'b0;
            if (req_valid) begin
                state   <= T2;
                req_idx <= adr[6:0];
                req_rd  <= rd;
                req_wr  <= wr && !rd;
                req_ie  <= ie_hit;
                sel     <= 1'b1;
            end else begin
                state <= IDLE;
                sel   <= 1'b0;
            end
        end else begin
            case (state)
                T2: begin
                    state  <= T3;
                    din_oe <= req_rd;
                end
                T3: state <= T4;
                T4: begin
                    state  <= IDLE;
                    sel    <= 1'b0;
                    din_oe <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Only valid hits reach T4, so req_wr alone qualifies the commit.
    assign commit = (state == T4) && req_wr;

    hram_mem u_mem (
        .clk   (clk),
        .addr  (req_idx),
        .we    (commit && !req_ie),
        .re    (state == T2),
        .wdata (dout),
        .rdata (mem_rdata)
    );

`ifdef HRAM_IE_EN
    logic [4:0] ie;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ie <= '0;
        end else if (commit && req_ie) begin
            ie <= dout[4:0];
        end
    end

    assign rd_data = req_ie ? {3'b111, ie} : mem_rdata;
`else
    assign rd_data = mem_rdata;
`endif

    // Select and both data sources are flops, so din never sees adr combinationally.
    assign din = din_oe ? rd_data : BUS_IDLE_DATA;

endmodule

// File: tb/tb_cpu_hram_responder.sv
// Scoreboard bench for cpu_hram_responder; honours HRAM_IE_EN when defined.
module tb_cpu_hram_responder;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        mcyc_start = 1'b0;
    logic [15:0] adr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  dout = '0;
    logic [7:0]  din;
    logic        din_oe;
    logic        sel;

    cpu_hram_responder dut (
        .clk        (clk),
        .nreset     (nreset),
        .mcyc_start (mcyc_start),
        .adr        (adr),
        .rd         (rd),
        .wr         (wr),
        .dout       (dout),
        .din        (din),
        .din_oe     (din_oe),
        .sel        (sel)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [3:0] o_sel;
    logic [3:0] o_oe;
    logic [7:0] o_din [4];
    logic [7:0] exp_q [$];
    logic [7:0] ref_mem [128];
    logic [4:0] ref_ie = '0;

    function automatic logic is_hit(input logic [15:0] a);
`ifdef HRAM_IE_EN
        return (a >= 16'hFF80) || (a == 16'hFFFF) ? ((a >= 16'hFF80 && a <= 16'hFFFE) || a == 16'hFFFF) : 1'b0;
`else
        return (a >= 16'hFF80) && (a <= 16'hFFFE);
`endif
    endfunction

    function automatic logic [7:0] model_read(input logic [15:0] a);
        if (a == 16'hFFFF) return {3'b111, ref_ie};
        return ref_mem[a[6:0]];
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        if (a == 16'hFFFF) ref_ie = d[4:0];
        else ref_mem[a[6:0]] = d;
    endtask

    // Drives one 4-T M-cycle (T1 in the idle slot) and records outputs for T1..T4.
    task automatic mcycle(input logic [15:0] a, input logic r, input logic w, input logic [7:0] d);
        @(negedge clk);
        o_sel[0] = sel; o_oe[0] = din_oe; o_din[0] = din;
        mcyc_start = 1'b1; adr = a; rd = r; wr = w;
        for (int t = 1; t < 4; t++) begin
            @(negedge clk);
            o_sel[t] = sel; o_oe[t] = din_oe; o_din[t] = din;
            if (t == 1) begin
                mcyc_start = 1'b0;
                dout = d;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        n_checks += 3;
        if (sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b expected 0", sel); end
        if (din_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", din_oe); end
        if (din !== 8'hFF) begin n_fail++; $display("FAIL reset_din: got %h expected ff", din); end
        repeat (3) @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_hram_rw;
        logic [7:0] e;
        mcycle(16'hFF80, 1'b0, 1'b1, 8'hA5);
        model_write(16'hFF80, 8'hA5);
        n_checks += 2;
        if (o_sel !== 4'b1110) begin n_fail++; $display("FAIL wr_sel: got %b expected 1110", o_sel); end
        if (o_oe !== 4'b0000) begin n_fail++; $display("FAIL wr_oe: got %b expected 0000", o_oe); end
        exp_q.push_back(8'hA5);
        mcycle(16'hFF80, 1'b1, 1'b0, 8'h00);
        e = exp_q.pop_front();
        n_checks += 4;
        if (o_sel !== 4'b1110) begin n_fail++; $display("FAIL rd_sel: got %b expected 1110", o_sel); end
        if (o_oe !== 4'b1100) begin n_fail++; $display("FAIL rd_oe: got %b expected 1100", o_oe); end
        if (o_din[2] !== e) begin n_fail++; $display("FAIL rd_din_t3: got %h expected %h", o_din[2], e); end
        if (o_din[3] !== e) begin n_fail++; $display("FAIL rd_din_t4: got %h expected %h", o_din[3], e); end
    endtask

    task automatic test_unmapped;
        logic [15:0] addrs [3];
        addrs[0] = 16'hFF7F; addrs[1] = 16'h0000; addrs[2] = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            if (is_hit(addrs[i])) continue;
            mcycle(addrs[i], 1'b1, 1'b0, 8'h00);
            n_checks += 3;
            if (o_sel !== 4'b0000) begin n_fail++; $display("FAIL unmapped_sel %h: got %b expected 0000", addrs[i], o_sel); end
            if (o_oe !== 4'b0000) begin n_fail++; $display("FAIL unmapped_oe %h: got %b expected 0000", addrs[i], o_oe); end
            if ({o_din[0], o_din[1], o_din[2], o_din[3]} !== 32'hFFFF_FFFF)
                begin n_fail++; $display("FAIL unmapped_din %h: got %h %h %h %h expected ff", addrs[i], o_din[0], o_din[1], o_din[2], o_din[3]); end
        end
    endtask

    task automatic test_ie;
`ifdef HRAM_IE_EN
        logic [7:0] wv [2];
        logic [7:0] ev [2];
        logic [4:0] iv [2];
        wv[0] = 8'hFF; ev[0] = 8'hFF; iv[0] = 5'h1F;
        wv[1] = 8'h00; ev[1] = 8'hE0; iv[1] = 5'h00;
        for (int i = 0; i < 2; i++) begin
            mcycle(16'hFFFF, 1'b0, 1'b1, wv[i]);
            model_write(16'hFFFF, wv[i]);
            exp_q.push_back(ev[i]);
            mcycle(16'hFFFF, 1'b1, 1'b0, 8'h00);
            n_checks += 3;
            if (dut.ie !== iv[i]) begin n_fail++; $display("FAIL ie_reg: got %h expected %h", dut.ie, iv[i]); end
            if (o_oe !== 4'b1100) begin n_fail++; $display("FAIL ie_oe: got %b expected 1100", o_oe); end
            if (o_din[2] !== exp_q[0]) begin n_fail++; $display("FAIL ie_din: got %h expected %h", o_din[2], exp_q[0]); end
            void'(exp_q.pop_front());
        end
`else
        mcycle(16'hFFFF, 1'b0, 1'b1, 8'hFF);
        n_checks += 1;
        if (o_sel !== 4'b0000) begin n_fail++; $display("FAIL ie_absent_sel: got %b expected 0000", o_sel); end
`endif
    endtask

    task automatic test_reset_midcycle;
        mcycle(16'hFFFE, 1'b0, 1'b1, 8'h5A);
        model_write(16'hFFFE, 8'h5A);
        @(negedge clk);
        mcyc_start = 1'b1; adr = 16'hFFFE; rd = 1'b0; wr = 1'b1;
        @(negedge clk);
        mcyc_start = 1'b0; dout = 8'h3C;
        @(negedge clk);
        nreset = 1'b0;
        #1;
        n_checks += 3;
        if (sel !== 1'b0) begin n_fail++; $display("FAIL midreset_sel: got %b expected 0", sel); end
        if (din_oe !== 1'b0) begin n_fail++; $display("FAIL midreset_oe: got %b expected 0", din_oe); end
        if (din !== 8'hFF) begin n_fail++; $display("FAIL midreset_din: got %h expected ff", din); end
        ref_ie = '0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        exp_q.push_back(model_read(16'hFFFE));
        mcycle(16'hFFFE, 1'b1, 1'b0, 8'h00);
        n_checks += 1;
        if (o_din[2] !== exp_q[0]) begin n_fail++; $display("FAIL midreset_dropped: got %h expected %h", o_din[2], exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_abort;
        mcycle(16'hFF90, 1'b0, 1'b1, 8'h77);
        model_write(16'hFF90, 8'h77);
        @(negedge clk);
        mcyc_start = 1'b1; adr = 16'hFF90; rd = 1'b0; wr = 1'b1;
        @(negedge clk);
        mcyc_start = 1'b0; dout = 8'h11;
        @(negedge clk);
        o_sel[0] = sel;
        mcyc_start = 1'b1; rd = 1'b1; wr = 1'b0;
        exp_q.push_back(model_read(16'hFF90));
        for (int t = 1; t < 4; t++) begin
            @(negedge clk);
            o_sel[t] = sel; o_oe[t] = din_oe; o_din[t] = din;
            mcyc_start = 1'b0;
        end
        n_checks += 4;
        if ({o_sel[0], o_sel[1]} !== 2'b11) begin n_fail++; $display("FAIL abort_sel: got %b%b expected 11", o_sel[0], o_sel[1]); end
        if (o_oe[3:1] !== 3'b110) begin n_fail++; $display("FAIL abort_oe: got %b expected 110", o_oe[3:1]); end
        if (o_din[2] !== exp_q[0]) begin n_fail++; $display("FAIL abort_din_t3: got %h expected %h", o_din[2], exp_q[0]); end
        if (o_din[3] !== exp_q[0]) begin n_fail++; $display("FAIL abort_din_t4: got %h expected %h", o_din[3], exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_random;
        logic [15:0] a;
        logic [1:0]  op;
        logic [7:0]  d;
        logic        h;
        logic [7:0]  e;
        for (int i = 0; i < 127; i++) begin
            d = 8'($urandom);
            mcycle(16'hFF80 + 16'(i), 1'b0, 1'b1, d);
            model_write(16'hFF80 + 16'(i), d);
        end
        for (int n = 0; n < 1000; n++) begin
            a  = 16'($urandom_range(16'hFF70, 16'hFFFF));
            op = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            h  = is_hit(a);
            if (h && op[0]) exp_q.push_back(model_read(a));
            mcycle(a, op[0], op[1], d);
            n_checks += 2;
            if (o_sel !== ((h && op != 2'b00) ? 4'b1110 : 4'b0000))
                begin n_fail++; $display("FAIL rand_sel %h op%0d: got %b", a, op, o_sel); end
            if (o_oe !== ((h && op[0]) ? 4'b1100 : 4'b0000))
                begin n_fail++; $display("FAIL rand_oe %h op%0d: got %b", a, op, o_oe); end
            if (h && op[0]) begin
                n_checks += 1;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_queue: empty expected queue");
                end else begin
                    e = exp_q.pop_front();
                    if (o_din[2] !== e || o_din[3] !== e)
                        begin n_fail++; $display("FAIL rand_din %h: got %h/%h expected %h", a, o_din[2], o_din[3], e); end
                end
            end else begin
                n_checks += 1;
                if (o_din[2] !== 8'hFF || o_din[3] !== 8'hFF)
                    begin n_fail++; $display("FAIL rand_idle_din %h: got %h/%h expected ff", a, o_din[2], o_din[3]); end
            end
            if (h && op == 2'b10) model_write(a, d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hram_rw();
        test_unmapped();
        test_ie();
        test_reset_midcycle();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_hram_responder.md
# cpu_hram_responder

Bus-side responder for the SM83 core's external M-cycle bus: decodes CPU addresses, serves reads by driving `din` and commits writes from `dout` for high RAM (FF80–FFFE) and, optionally, the IE register (FFFF). It is the memory end of the fetch/read/write sequences the CPU issues each M-cycle, such as opcode fetch at PC or immediate fetch in M2. It sits beside the CPU core in the top-level bus fabric, one instance per system.

## Interface
- No parameters.
- `clk`  in  1  system clock, one T-cycle per rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `mcyc_start`  in  1  high for exactly the T1 cycle of each CPU M-cycle.
- `adr`  in  16  CPU address; valid and stable from T1 through T4.
- `rd`  in  1  CPU read request for this M-cycle; sampled at T1.
- `wr`  in  1  CPU write request for this M-cycle; sampled at T1.
- `dout`  in  8  CPU write data; valid at T3 and T4.
- `din`  out  8  read data toward CPU; 8'hFF when not driving.
- `din_oe`  out  1  high while this block drives `din`.
- `sel`  out  1  high from T2 to T4 of any M-cycle addressed to this block.

## Operation
- Decode, sampled at T1: HRAM hit when `adr[15:7]` = 9'h1FF and `adr[6:0]` != 7'h7F; IE hit when `adr` = 16'hFFFF and the feature is compiled in. A hit is HRAM or IE.
- FSM states:
  - IDLE: entered on reset.
  - T1→T2 on `mcyc_start`. The address, rd, wr and hit are latched into a request register at this edge.
  - T2→T3→T4→IDLE on successive edges.
  - A `mcyc_start` seen in T4 or IDLE goes directly to T2. This is the back-to-back case and leaves no idle gap.
  - A `mcyc_start` seen in T2 or T3 is a protocol violation. The current M-cycle is aborted: no write commits, and the FSM restarts at T2 using the new request.
- Read, when the latched request is rd with a hit: `din_oe`=1 and `din`=data in T3 and T4. The data comes from HRAM at `adr[6:0]`, or from IE as {3'b111, ie[4:0]}.
- Write, when the latched request is wr with a hit: data is `dout` captured at the T4 edge.
  - HRAM: the byte commits at the end of T4.
  - IE: bits [4:0] commit at the end of T4 and bits [7:5] are ignored.
- `rd` and `wr` both high at T1 is a violation. The cycle is treated as a read and no write occurs.
- Neither `rd` nor `wr`, or no hit: `sel` stays 0, `din_oe` stays 0 and there is no state change.
- Address wrap: FF7F and 0000 are not hits. FFFE is the last HRAM byte. FFFF is a hit only with the feature compiled in.

## Timing
- Reset values: FSM=IDLE, `din`=8'hFF, `din_oe`=0, `sel`=0, IE=5'b00000. HRAM contents are not initialised.
- Reset asserted mid-cycle: all outputs return to their reset values immediately (asynchronously), and any pending write is dropped.
- Read latency: data is visible at T3 (two edges after the T1 sample) and held through T4. It is registered and glitch-free.
- Write-then-read of the same address in back-to-back M-cycles returns the new value.
- `sel` is asserted in T2, T3 and T4 for every hit, including an aborted cycle up to the abort point.
- Outputs are registered only. There is no combinational path from `adr` to `din`.

## Configuration
- `HRAM_IE_EN`
  - Defined: FFFF decodes as IE, a 5-bit register that reads back with bits [7:5]=1.
  - Undefined: FFFF is not a hit (`sel`=0, `din_oe`=0) and the IE flops are absent.

## Structure
- Shared package `cpu_bus_pkg`:
  - enum `tstate_t` with values IDLE, T2, T3, T4;
  - constants `HRAM_BASE`=16'hFF80, `HRAM_LAST`=16'hFFFE, `IE_ADR`=16'hFFFF, `BUS_IDLE_DATA`=8'hFF.
- One sub-module, `hram_mem`: 128×8 synchronous single-port RAM with write enable, read at the T2 edge. Entry 127 is unused.

## Test plan
- Write 8'hA5 to FF80 in one M-cycle, then read FF80 in the next → `din`=8'hA5 with `din_oe`=1 in T3 and T4 of the read, and `din_oe`=0 in the other T-states.
- Read FF7F, then 0000, then FFFF with `HRAM_IE_EN` undefined → `sel`=0, `din_oe`=0, `din`=8'hFF throughout.
- With `HRAM_IE_EN` defined, write 8'hFF to FFFF, then read it → reads 8'hFF, with internal IE=5'h1F. Write 8'h00, then read → 8'hE0.
- Write 8'h3C to FFFE and assert `nreset` low during T3 → outputs reset immediately, and a following read of FFFE does not return 8'h3C unless it was already stored.
- Issue `mcyc_start` again during T3 of a write to FF90 of 8'h11, with the new cycle reading FF90 → the write is dropped and the read returns the prior FF90 value.
- Run 1000 random back-to-back M-cycles across FF70–FFFF against a reference memory model → every read matches the model and `din_oe` is asserted only for hits.
